// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, word size and the index-width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Ceiling log2, used at elaboration time for index and counter widths.
  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a synchronous byte-enabled write and an
// asynchronous read on the same index. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [IW-1:0]         i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed latency.
// Define DMEM_ERR_EN to flag misaligned or out-of-range addresses via rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IW            = clog2_f(DEPTH_WORDS);
  localparam int CW            = clog2_f(LATENCY + 1);
  localparam bit DIRECT_ACCESS = (LATENCY == 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_acc_we;
  logic [AW-1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [3:0]    w_acc_be;
  logic          w_fire;
  logic          w_err;
  logic [31:0]   w_rdata;
  logic [31:0]   w_rsp_data;

  // With a single-cycle latency the access happens on the accept edge,
  // so the live request fields feed the array instead of the latched copy.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    w_acc_be    = r_be;
    if (DIRECT_ACCESS && (r_state == IDLE)) begin
      w_acc_we    = req_we;
      w_acc_addr  = req_addr;
      w_acc_wdata = req_wdata;
      w_acc_be    = req_be;
    end else begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_be    = r_be;
    end
  end

  assign w_fire = (DIRECT_ACCESS && (r_state == IDLE) && req_valid) ||
                  ((r_state == BUSY) && (r_cnt == CW'(1)));

`ifdef DMEM_ERR_EN
  assign w_err = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (IW + 2)) != '0);
`else
  // Byte offset and upper address bits are deliberately ignored here.
  logic w_unused_addr;
  assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[AW-1:IW+2]};
  assign w_err         = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_fire && w_acc_we && !w_err),
    .i_be    (w_acc_be),
    .i_idx   (w_acc_addr[2 +: IW]),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_rdata)
  );

  // Stores and erroring accesses respond with zero data.
  always_comb begin
    w_rsp_data = 32'h0000_0000;
    if (w_acc_we || w_err) begin
      w_rsp_data = 32'h0000_0000;
    end else begin
      w_rsp_data = w_rdata;
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0000_0000;
      r_be        <= 4'h0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            if (DIRECT_ACCESS) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_data;
            r_rsp_err   <= w_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0000_0000;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
